interrupt_controller: RTL and testbench
=======================================

// Module: interrupt_controller
// PURPOSE
//   Prioritised, nestable interrupt controller for the MIPS core. Captures the external
//   request lines, masks and arbitrates them, and presents one request plus a handler
//   vector to the CPU. Tracks which interrupt levels are in service until the matching eret.
//   Sits between the board-level request pins and the CPU's exception/PC-select logic in main.
// PARAMETERS
//   N_IRQ      3              number of request lines; line 0 has the highest priority
//   VEC_BASE   32'h0000_0100  handler address for line 0
//   VEC_STRIDE 32'h0000_0020  address spacing between consecutive handlers
// PORTS
//   Clock     in   1          single system clock, rising edge
//   Reset     in   1          asynchronous, active-high reset
//   ir        in   N_IRQ      raw requests; may be asynchronous; each pulse must be >=1 Clock period
//   int_en    in   1          global enable from CPU status (IE bit)
//   cfg_we    in   1          write strobe for the mask register
//   cfg_mask  in   N_IRQ      mask data; 1 = line disabled
//   int_ack   in   1          one-cycle pulse: CPU has taken the request at an instruction boundary
//   eret      in   1          one-cycle pulse: CPU has returned from a handler
//   int_req   out  1          request to CPU (level)
//   int_vec   out  32         handler address; valid while int_req=1
//   int_id    out  clog2(N_IRQ)  selected line number; valid while int_req=1
//   pending_o out  N_IRQ      pending register, for debug and status
//   isr_o     out  N_IRQ      in-service register, for debug and status
// BEHAVIOUR
//   Reset: sync/edge flops=0, pending=0, isr=0, mask=0 (all enabled), state=IDLE,
//     int_req=0, int_id=0, int_vec=VEC_BASE.
//   Capture: per-line 2-flop synchroniser followed by a rising-edge detector.
//     pending[i] is set on the 3rd Clock edge after ir[i] rises.
//     A line that is already high when Reset is released produces exactly one request.
//     A line held high produces one request only; no re-trigger until it falls and rises again.
//   Eligible line: pending & ~mask, and strictly higher priority (lower index) than the
//     highest-priority set bit of isr. When isr=0, every unmasked pending line is eligible.
//   Winner: the lowest-index eligible line.
//     int_vec = VEC_BASE + winner*VEC_STRIDE, 32-bit unsigned, wraps modulo 2^32.
//   FSM (2 states):
//     IDLE -> REQ when int_en=1 and an eligible line exists. On that edge, latch int_id and
//       int_vec; int_req=1 from the following cycle.
//     REQ: int_id and int_vec are frozen. A later higher-priority arrival does NOT replace
//       them. Mask writes and int_en=0 do not withdraw the request.
//     REQ -> IDLE on int_ack: pending[int_id] cleared, isr[int_id] set, int_req=0 the next cycle.
//       The earliest re-request is the cycle after that.
//     int_ack while IDLE is ignored.
//   eret: clears the highest-priority set bit of isr. Ignored when isr=0. Legal in any state.
//   Mask: cfg_we loads mask on the Clock edge.
//     Masked lines still latch into pending and fire later once unmasked.
//   Simultaneous events (same edge):
//     - new edge on line k and int_ack for line k: pending[k] ends at 1 (set wins).
//     - eret and int_ack: eret clears the old top isr bit, then the ack bit is set.
//     - eret and an IDLE->REQ decision: eligibility uses the isr value before the eret.
//   Reset mid-operation: every register returns to its reset value at once,
//     and int_req drops asynchronously.
// STRUCTURE
//   Package mips_irq_pkg: N_IRQ default, state encoding (IDLE, REQ), VEC_BASE/VEC_STRIDE
//     defaults, and a priority-encode function (lowest set index) shared by winner
//     select and eret.
//   Sub-module irq_sync_edge: 2-flop synchroniser plus rising-edge pulse, one instance per line.
//   Top level: pending/mask/isr registers, eligibility logic, FSM, vector adder.
// TESTING
//   1. Reset, ir[0] high for 2 cycles, int_en=1
//      -> int_req=1 four edges after the rise; int_id=0; int_vec=32'h100.
//      Then int_ack -> isr=3'b001, pending=0, int_req=0.
//   2. ir[2] and ir[1] rise together, int_en=1
//      -> int_id=1, int_vec=32'h120. After ack and eret: int_id=2, int_vec=32'h140.
//   3. Nesting: ack line 2 (isr=3'b100), then raise ir[0] -> preempts with int_id=0.
//      ir[2] raised again while isr[2]=1 -> int_req stays 0 until eret.
//   4. cfg_mask=3'b010, pulse ir[1] -> pending_o=3'b010 and int_req=0.
//      Write cfg_mask=0 -> int_req=1 next cycle with int_id=1.
//   5. In REQ for line 2, pulse ir[0] -> int_id stays 2 until ack.
//      Line 0 is requested two cycles after the ack.
//   6. Assert Reset while int_req=1 and isr!=0
//      -> int_req, pending_o, isr_o all 0 immediately; no request after release with ir low.

Source files
------------

// File: rtl/mips_irq_pkg.sv
// Shared definitions for the MIPS interrupt controller: defaults, FSM encoding,
// and the lowest-set-index priority encoder used for both arbitration and eret.
package mips_irq_pkg;

  localparam int          N_IRQ_DEF      = 3;
  localparam logic [31:0] VEC_BASE_DEF   = 32'h0000_0100;
  localparam logic [31:0] VEC_STRIDE_DEF = 32'h0000_0020;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } irq_state_t;

  // Returns the index of the lowest set bit (0 when v is all-zero; callers test |v).
  function automatic int prio_enc(input logic [31:0] v);
    prio_enc = 0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) prio_enc = i;
    end
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchroniser for one raw request line, followed by a rising-edge
// detector that emits a single-cycle pulse per low-to-high transition.
module irq_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic s1, s2, s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // s3 resets low, so a line already high at reset release still yields one pulse.
  assign rise = s2 & ~s3;

endmodule

// File: rtl/interrupt_controller.sv
// Prioritised, nestable interrupt controller: captures request edges, masks and
// arbitrates them against the in-service set, and holds one request for the CPU.
module interrupt_controller
  import mips_irq_pkg::*;
#(
  parameter int          N_IRQ      = N_IRQ_DEF,
  parameter logic [31:0] VEC_BASE   = VEC_BASE_DEF,
  parameter logic [31:0] VEC_STRIDE = VEC_STRIDE_DEF,
  localparam int         IDW        = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] ir,
  input  logic             int_en,
  input  logic             cfg_we,
  input  logic [N_IRQ-1:0] cfg_mask,
  input  logic             int_ack,
  input  logic             eret,
  output logic             int_req,
  output logic [31:0]      int_vec,
  output logic [IDW-1:0]   int_id,
  output logic [N_IRQ-1:0] pending_o,
  output logic [N_IRQ-1:0] isr_o
);

  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] pending, pending_n;
  logic [N_IRQ-1:0] mask;
  logic [N_IRQ-1:0] isr, isr_n;
  logic [N_IRQ-1:0] cand, elig;
  logic             isr_any;
  int               isr_top;
  int               win;
  logic [IDW-1:0]   isr_top_id;
  logic [IDW-1:0]   win_id;
  logic [31:0]      win_vec;
  irq_state_t       state, state_n;
  logic             load, take;
  logic [IDW-1:0]   id_q;
  logic [31:0]      vec_q;

  for (genvar g = 0; g < N_IRQ; g++) begin : g_sync
    irq_sync_edge u_sync (
      .clk  (clk),
      .rst  (rst),
      .d    (ir[g]),
      .rise (rise[g])
    );
  end

  // Only lines strictly above the most urgent in-service level may preempt it.
  always_comb begin
    isr_any    = |isr;
    isr_top    = prio_enc(32'(isr));
    isr_top_id = IDW'(isr_top);
    cand       = pending & ~mask;
    elig       = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      elig[i] = cand[i] & (~isr_any | (i < isr_top));
    end
    win     = prio_enc(32'(elig));
    win_id  = IDW'(win);
    win_vec = VEC_BASE + 32'(win) * VEC_STRIDE;
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    take    = 1'b0;
    case (state)
      IDLE: begin
        if (int_en && (|elig)) begin
          state_n = REQ;
          load    = 1'b1;
        end
      end
      REQ: begin
        if (int_ack) begin
          state_n = IDLE;
          take    = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // eret retires the old top level before an ack in the same cycle marks the new one.
  always_comb begin
    isr_n = isr;
    if (eret && isr_any) isr_n[isr_top_id] = 1'b0;
    if (take) isr_n[id_q] = 1'b1;
    pending_n = pending;
    if (take) pending_n[id_q] = 1'b0;
    pending_n = pending_n | rise;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      id_q    <= '0;
      vec_q   <= VEC_BASE;
      pending <= '0;
      isr     <= '0;
      mask    <= '0;
    end else begin
      state   <= state_n;
      pending <= pending_n;
      isr     <= isr_n;
      if (load) begin
        id_q  <= win_id;
        vec_q <= win_vec;
      end
      if (cfg_we) mask <= cfg_mask;
    end
  end

  assign int_req   = (state == REQ);
  assign int_id    = id_q;
  assign int_vec   = vec_q;
  assign pending_o = pending;
  assign isr_o     = isr;

endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller: directed scenarios plus randomized traffic, all
// outputs compared each cycle against a behavioural model of the controller.
module tb_interrupt_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  ir;
  logic        int_en;
  logic        cfg_we;
  logic [2:0]  cfg_mask;
  logic        int_ack;
  logic        eret;
  logic        int_req;
  logic [31:0] int_vec;
  logic [1:0]  int_id;
  logic [2:0]  pending_o;
  logic [2:0]  isr_o;

  int n_checks = 0;
  int n_pass   = 0;

  interrupt_controller dut (
    .clk       (clk),
    .rst       (rst),
    .ir        (ir),
    .int_en    (int_en),
    .cfg_we    (cfg_we),
    .cfg_mask  (cfg_mask),
    .int_ack   (int_ack),
    .eret      (eret),
    .int_req   (int_req),
    .int_vec   (int_vec),
    .int_id    (int_id),
    .pending_o (pending_o),
    .isr_o     (isr_o)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [2:0]  m_pend, m_mask, m_isr, m_last_ir, m_rise1, m_rise2;
  logic        m_req;
  int          m_id;
  logic [31:0] m_vec;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_pend = '0; m_mask = '0; m_isr = '0; m_last_ir = '0;
    m_rise1 = '0; m_rise2 = '0;
    m_req = 1'b0; m_id = 0; m_vec = 32'h100;
  endtask

  // One clock edge of the controller, from its rules: a rise seen at an edge lands in
  // pending two edges later; arbitration and eret use the pre-edge isr.
  task automatic model_step();
    logic [2:0] isr_n, pend_n;
    int top, win;
    top = 3;
    for (int i = 2; i >= 0; i--) if (m_isr[i]) top = i;
    win = -1;
    for (int i = 0; i < 3; i++)
      if (win < 0 && m_pend[i] && !m_mask[i] && i < top) win = i;
    isr_n  = m_isr;
    pend_n = m_pend;
    if (eret && m_isr != 3'b000) isr_n[top] = 1'b0;
    if (m_req && int_ack) begin
      isr_n[m_id]  = 1'b1;
      pend_n[m_id] = 1'b0;
    end
    pend_n = pend_n | m_rise2;
    if (!m_req) begin
      if (int_en && win >= 0) begin
        m_req = 1'b1;
        m_id  = win;
        m_vec = 32'h100 + 32'(win) * 32'h20;
      end
    end else if (int_ack) begin
      m_req = 1'b0;
    end
    if (cfg_we) m_mask = cfg_mask;
    m_rise2   = m_rise1;
    m_rise1   = ir & ~m_last_ir;
    m_last_ir = ir;
    m_isr     = isr_n;
    m_pend    = pend_n;
  endtask

  task automatic compare_all();
    check("int_req", {31'b0, int_req}, {31'b0, m_req});
    check("pending", {29'b0, pending_o}, {29'b0, m_pend});
    check("isr", {29'b0, isr_o}, {29'b0, m_isr});
    if (m_req) begin
      check("int_id", {30'b0, int_id}, 32'(m_id));
      check("int_vec", int_vec, m_vec);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    #1;
    compare_all();
  endtask

  task automatic pulse_ir(input logic [2:0] m);
    ir = m;
    cycle();
    cycle();
    ir = 3'b000;
  endtask

  task automatic do_ack();
    int_ack = 1'b1;
    cycle();
    int_ack = 1'b0;
  endtask

  task automatic do_eret();
    eret = 1'b1;
    cycle();
    eret = 1'b0;
  endtask

  task automatic wait_req(input int max_cycles);
    for (int k = 0; k < max_cycles && !int_req; k++) cycle();
    if (!int_req) check("wait_req_timeout", {31'b0, int_req}, 32'd1);
  endtask

  task automatic async_reset();
    #3 rst = 1'b1;
    #1;
    model_reset();
    check("rst_int_req", {31'b0, int_req}, 32'd0);
    check("rst_pending", {29'b0, pending_o}, 32'd0);
    check("rst_isr", {29'b0, isr_o}, 32'd0);
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ir = '0; int_en = 1'b1; cfg_we = 1'b0; cfg_mask = '0;
    int_ack = 1'b0; eret = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_int_req", {31'b0, int_req}, 32'd0);
    check("reset_int_id", {30'b0, int_id}, 32'd0);
    check("reset_int_vec", int_vec, 32'h100);
    check("reset_pending", {29'b0, pending_o}, 32'd0);
    check("reset_isr", {29'b0, isr_o}, 32'd0);
    rst = 1'b0;

    // 1: single request on line 0, four edges after the rise
    ir = 3'b001;
    cycle(); cycle();
    ir = 3'b000;
    cycle();
    check("t1_no_req_edge3", {31'b0, int_req}, 32'd0);
    cycle();
    check("t1_req_edge4", {31'b0, int_req}, 32'd1);
    check("t1_id", {30'b0, int_id}, 32'd0);
    check("t1_vec", int_vec, 32'h100);
    do_ack();
    check("t1_isr", {29'b0, isr_o}, 32'b001);
    check("t1_pending", {29'b0, pending_o}, 32'd0);
    check("t1_req_drop", {31'b0, int_req}, 32'd0);
    do_eret();

    // 2: simultaneous lines 1 and 2
    pulse_ir(3'b110);
    wait_req(10);
    check("t2_id1", {30'b0, int_id}, 32'd1);
    check("t2_vec1", int_vec, 32'h120);
    do_ack();
    do_eret();
    wait_req(10);
    check("t2_id2", {30'b0, int_id}, 32'd2);
    check("t2_vec2", int_vec, 32'h140);
    do_ack();
    check("t2_isr", {29'b0, isr_o}, 32'b100);

    // 3: nesting and blocked re-trigger of an in-service level
    pulse_ir(3'b001);
    wait_req(10);
    check("t3_preempt_id", {30'b0, int_id}, 32'd0);
    do_ack();
    check("t3_isr_nest", {29'b0, isr_o}, 32'b101);
    do_eret();
    check("t3_isr_after_eret", {29'b0, isr_o}, 32'b100);
    pulse_ir(3'b100);
    repeat (6) cycle();
    check("t3_blocked", {31'b0, int_req}, 32'd0);
    do_eret();
    wait_req(10);
    check("t3_id_after_eret", {30'b0, int_id}, 32'd2);
    do_ack();
    do_eret();

    // 4: masked line latches, fires once unmasked
    cfg_we = 1'b1; cfg_mask = 3'b010;
    cycle();
    cfg_we = 1'b0;
    pulse_ir(3'b010);
    repeat (4) cycle();
    check("t4_pending", {29'b0, pending_o}, 32'b010);
    check("t4_masked_noreq", {31'b0, int_req}, 32'd0);
    cfg_we = 1'b1; cfg_mask = 3'b000;
    cycle();
    cfg_we = 1'b0;
    cycle();
    check("t4_unmasked_req", {31'b0, int_req}, 32'd1);
    check("t4_id", {30'b0, int_id}, 32'd1);
    do_ack();
    do_eret();

    // 5: request frozen during REQ; line 0 follows two cycles after ack
    pulse_ir(3'b100);
    wait_req(10);
    pulse_ir(3'b001);
    repeat (5) cycle();
    check("t5_frozen_id", {30'b0, int_id}, 32'd2);
    int_ack = 1'b1;
    cycle();
    int_ack = 1'b0;
    check("t5_gap", {31'b0, int_req}, 32'd0);
    cycle();
    check("t5_rereq", {31'b0, int_req}, 32'd1);
    check("t5_rereq_id", {30'b0, int_id}, 32'd0);
    do_ack();
    do_eret();
    do_eret();

    // 6: asynchronous reset while requesting with isr set
    pulse_ir(3'b010);
    wait_req(10);
    do_ack();
    pulse_ir(3'b001);
    wait_req(10);
    async_reset();
    repeat (8) cycle();
    check("t6_quiet", {31'b0, int_req}, 32'd0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 3; i++)
        if ($urandom_range(0, 3) == 0) ir[i] = ~ir[i];
      int_en  = ($urandom_range(0, 7) != 0);
      cfg_we  = ($urandom_range(0, 15) == 0);
      cfg_mask = 3'($urandom_range(0, 7));
      int_ack = m_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      eret    = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 499) == 0) async_reset();
      else cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
